// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the registered ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASSB = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_OR    = 4'd3,
    OP_AND   = 4'd4,
    OP_XOR   = 4'd5,
    OP_NOT   = 4'd6,
    OP_PASSA = 4'd7,
    OP_ADC   = 4'd8,
    OP_SBB   = 4'd9,
    OP_SHL   = 4'd10,
    OP_SHR   = 4'd11,
    OP_ASR   = 4'd12,
    OP_MUL   = 4'd13
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

  typedef logic [3:0] flags_t;

  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the control FSM (master) and alu_seq (slave).
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Sel;
  logic             out_valid;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] ResultHi;
  logic             Carry;
  logic             Zero;
  logic             Neg;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Sel,
    input  in_ready, out_valid, Result, ResultHi, Carry, Zero, Neg, Ovf
  );

  modport slave (
    input  in_valid, A, B, Sel,
    output in_ready, out_valid, Result, ResultHi, Carry, Zero, Neg, Ovf
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic               run;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_nxt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  // The final iteration's sum is presented directly so the top can register it on the done edge.
  assign done    = run && (cnt == CNT_W'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready operand handshake and persistent C/Z/N/V flags.
// Define ALU_MUL_EN to build opcode 13 as a WIDTH-cycle unsigned multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_seq_if.slave bus
);

  localparam int SHAMT_W = shamt_w(WIDTH);
  localparam int M       = WIDTH - 1;

  logic [WIDTH-1:0]        res_d;
  flags_t                  flg_d;
  logic                    c_d, v_d;
  logic [WIDTH:0]          sum, shl_t, shr_t;
  logic signed [WIDTH:0]   asr_t;
  logic [SHAMT_W-1:0]      amt;

  logic [WIDTH-1:0]        result;
  flags_t                  flags;
  logic                    out_valid;
  logic                    cin;
  logic                    accept, single_acc;

  assign cin    = flags[FLG_C];
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    amt   = bus.B[SHAMT_W-1:0];
    sum   = '0;
    // Shift by one extra bit position so the last bit shifted out lands in a known slot.
    shl_t = {1'b0, bus.A} << amt;
    shr_t = {bus.A, 1'b0} >> amt;
    asr_t = $signed({bus.A, 1'b0}) >>> amt;
    res_d = bus.A;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (bus.Sel)
      OP_PASSB: res_d = bus.B;
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, (bus.Sel == OP_ADC) && cin};
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (bus.A[M] == bus.B[M]) && (sum[M] != bus.A[M]);
      end
      OP_SUB, OP_SBB: begin
        sum   = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, (bus.Sel == OP_SBB) && cin};
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (bus.A[M] != bus.B[M]) && (sum[M] != bus.A[M]);
      end
      OP_OR:  res_d = bus.A | bus.B;
      OP_AND: res_d = bus.A & bus.B;
      OP_XOR: res_d = bus.A ^ bus.B;
      OP_NOT: res_d = ~bus.B;
      OP_SHL: begin
        res_d = shl_t[WIDTH-1:0];
        c_d   = shl_t[WIDTH];
      end
      OP_SHR: begin
        res_d = shr_t[WIDTH:1];
        c_d   = shr_t[0];
      end
      OP_ASR: begin
        res_d = asr_t[WIDTH:1];
        c_d   = asr_t[0];
      end
      default: res_d = bus.A;
    endcase
    flg_d        = '0;
    flg_d[FLG_C] = c_d;
    flg_d[FLG_Z] = (res_d == '0);
    flg_d[FLG_N] = res_d[M];
    flg_d[FLG_V] = v_d;
  end

`ifdef ALU_MUL_EN
  state_e             state;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   result_hi;
  flags_t             mul_flg;

  assign bus.in_ready = (state == ST_IDLE);
  assign mul_start    = accept && (bus.Sel == OP_MUL);
  assign single_acc   = accept && (bus.Sel != OP_MUL);

  always_comb begin
    mul_flg        = '0;
    mul_flg[FLG_C] = (product[2*WIDTH-1:WIDTH] != '0);
    mul_flg[FLG_Z] = (product == '0);
    mul_flg[FLG_N] = product[2*WIDTH-1];
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.A),
    .b       (bus.B),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         state <= ST_IDLE;
    else if (mul_start) state <= ST_BUSY;
    else if (mul_done)  state <= ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          result_hi <= '0;
    else if (single_acc) result_hi <= '0;
    else if (mul_done)   result_hi <= product[2*WIDTH-1:WIDTH];
  end

  assign bus.ResultHi = result_hi;
`else
  assign bus.in_ready = 1'b1;
  assign single_acc   = accept;
  assign bus.ResultHi = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (single_acc) begin
        result    <= res_d;
        flags     <= flg_d;
        out_valid <= 1'b1;
      end
`ifdef ALU_MUL_EN
      else if (mul_done) begin
        result    <= product[WIDTH-1:0];
        flags     <= mul_flg;
        out_valid <= 1'b1;
      end
`endif
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.Result    = result;
  assign bus.Carry     = flags[FLG_C];
  assign bus.Zero      = flags[FLG_Z];
  assign bus.Neg       = flags[FLG_N];
  assign bus.Ovf       = flags[FLG_V];

endmodule
